// File: rtl/wb_pkg.sv
// wb_pkg: types and widths shared by the writeback arbiter, its load FIFO and
// its bus interface.
//   REG_W      register index width
//   DATA_W     write data width
//   wb_entry_t one buffered load return: valid flag, destination register, data
//   wb_commits true when an entry really writes the register file

package wb_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // Writes to register 0, and entries killed by a younger ALU write, are
  // consumed without asserting the write strobe.
  function automatic logic wb_commits(input wb_entry_t e);
    return e.valid && (e.rd != '0);
  endfunction

endpackage

// File: rtl/writeback_arbiter_if.sv
// writeback_arbiter_if: handshake and write-port bundle of the writeback arbiter.
//   alu_valid/alu_ready/alu_reg/alu_data   ALU result channel
//   ld_valid/ld_ready/ld_reg/ld_data       load return channel
//   ctrl_writeEnable/ctrl_writeReg/data_writeReg  registered register-file write
//   lq_count                               load FIFO occupancy
//   byp_reg_*/byp_hit_*/byp_data_*         decode bypass, only with WB_BYPASS_EN
// Modports: slave = the arbiter, master = the pipeline driving it.

interface writeback_arbiter_if #(
  parameter int LQ_DEPTH = 4
) ();
  import wb_pkg::*;

  localparam int CNT_W = $clog2(LQ_DEPTH) + 1;

  logic              alu_valid;
  logic              alu_ready;
  logic [REG_W-1:0]  alu_reg;
  logic [DATA_W-1:0] alu_data;

  logic              ld_valid;
  logic              ld_ready;
  logic [REG_W-1:0]  ld_reg;
  logic [DATA_W-1:0] ld_data;

  logic              ctrl_writeEnable;
  logic [REG_W-1:0]  ctrl_writeReg;
  logic [DATA_W-1:0] data_writeReg;
  logic [CNT_W-1:0]  lq_count;

`ifdef WB_BYPASS_EN
  logic [REG_W-1:0]  byp_reg_a;
  logic [REG_W-1:0]  byp_reg_b;
  logic              byp_hit_a;
  logic              byp_hit_b;
  logic [DATA_W-1:0] byp_data_a;
  logic [DATA_W-1:0] byp_data_b;
`endif

  modport slave (
    input  alu_valid, alu_reg, alu_data, ld_valid, ld_reg, ld_data,
    output alu_ready, ld_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg, lq_count
`ifdef WB_BYPASS_EN
    , input  byp_reg_a, byp_reg_b,
    output byp_hit_a, byp_hit_b, byp_data_a, byp_data_b
`endif
  );

  modport master (
    output alu_valid, alu_reg, alu_data, ld_valid, ld_reg, ld_data,
    input  alu_ready, ld_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg, lq_count
`ifdef WB_BYPASS_EN
    , output byp_reg_a, byp_reg_b,
    input  byp_hit_a, byp_hit_b, byp_data_a, byp_data_b
`endif
  );

endinterface

// File: rtl/wb_load_fifo.sv
// wb_load_fifo: in-order circular buffer of load returns for the writeback arbiter.
//   clock, ctrl_reset   clock and asynchronous active-low reset
//   push, push_entry    enqueue at tail (caller guarantees not full)
//   pop                 dequeue head (caller guarantees not empty)
//   head                current head entry
//   count               occupancy 0..LQ_DEPTH
//   inv_en, inv_rd      clear the valid bit of every stored entry targeting inv_rd
// LQ_DEPTH must be a power of two so the pointers wrap naturally.

module wb_load_fifo import wb_pkg::*; #(
  parameter int LQ_DEPTH = 4,
  localparam int AW    = $clog2(LQ_DEPTH),
  localparam int CNT_W = AW + 1
) (
  input  logic             clock,
  input  logic             ctrl_reset,
  input  logic             push,
  input  wb_entry_t        push_entry,
  input  logic             pop,
  output wb_entry_t        head,
  output logic [CNT_W-1:0] count,
  input  logic             inv_en,
  input  logic [REG_W-1:0] inv_rd
);

  wb_entry_t       mem [LQ_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  assign head = mem[rd_ptr];

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < LQ_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      // Invalidation only touches entries already stored; a load pushed in
      // the same cycle is younger than the ALU write and must survive. The
      // push below overrides the tail slot, which is free whenever push is set.
      for (int i = 0; i < LQ_DEPTH; i++) begin
        if (inv_en && (mem[i].rd == inv_rd)) begin
          mem[i].valid <= 1'b0;
        end
      end
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: final pipeline stage driving the register-file write port.
// Merges single-cycle ALU results with load returns buffered in wb_load_fifo,
// issuing at most one registered write per cycle and never dropping an
// accepted result. ALU results win unless the FIFO has been starved for
// STARVE_LIMIT consecutive ALU wins, in which case the FIFO head is forced out.
//   clock       system clock, rising edge
//   ctrl_reset  asynchronous active-low reset
//   bus         writeback_arbiter_if.slave: ALU and load channels, registered
//               write port, lq_count, and (with WB_BYPASS_EN) decode bypass
// Optional feature macro: WB_BYPASS_EN adds the combinational decode bypass.

module writeback_arbiter import wb_pkg::*; #(
  parameter int LQ_DEPTH     = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                clock,
  input  logic                ctrl_reset,
  writeback_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(LQ_DEPTH) + 1;
  localparam int SW    = $clog2(STARVE_LIMIT + 1);

  wb_entry_t         head;
  wb_entry_t         push_entry;
  logic [CNT_W-1:0]  lq_count;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              force_drain;
  logic              alu_win;
  logic [SW-1:0]     starve_cnt;

  logic              write_en_q;
  logic [REG_W-1:0]  write_reg_q;
  logic [DATA_W-1:0] write_data_q;

  assign fifo_empty  = (lq_count == '0);
  assign force_drain = !fifo_empty && (starve_cnt == SW'(STARVE_LIMIT));
  assign alu_win     = bus.alu_valid && !force_drain;
  assign pop         = !alu_win && !fifo_empty;
  // Full blocks a push even if the head pops this cycle.
  assign push        = bus.ld_valid && bus.ld_ready;

  assign push_entry.valid = 1'b1;
  assign push_entry.rd    = bus.ld_reg;
  assign push_entry.data  = bus.ld_data;

  assign bus.alu_ready = !force_drain;
  assign bus.ld_ready  = (lq_count != CNT_W'(LQ_DEPTH));
  assign bus.lq_count  = lq_count;

  wb_load_fifo #(
    .LQ_DEPTH (LQ_DEPTH)
  ) u_fifo (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (lq_count),
    .inv_en     (alu_win),
    .inv_rd     (bus.alu_reg)
  );

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      starve_cnt <= '0;
    end else if (pop || fifo_empty) begin
      starve_cnt <= '0;
    end else if (alu_win) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // A consumed write that does not commit (reg 0 or invalidated) still
  // updates index/data; only the strobe is suppressed.
  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      write_en_q   <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else if (alu_win) begin
      write_en_q   <= (bus.alu_reg != '0);
      write_reg_q  <= bus.alu_reg;
      write_data_q <= bus.alu_data;
    end else if (pop) begin
      write_en_q   <= wb_commits(head);
      write_reg_q  <= head.rd;
      write_data_q <= head.data;
    end else begin
      write_en_q   <= 1'b0;
    end
  end

  assign bus.ctrl_writeEnable = write_en_q;
  assign bus.ctrl_writeReg    = write_reg_q;
  assign bus.data_writeReg    = write_data_q;

`ifdef WB_BYPASS_EN
  // Lets decode pick up the value the register file absorbs on the coming edge.
  assign bus.byp_hit_a  = write_en_q && (write_reg_q == bus.byp_reg_a) && (bus.byp_reg_a != '0);
  assign bus.byp_hit_b  = write_en_q && (write_reg_q == bus.byp_reg_b) && (bus.byp_reg_b != '0);
  assign bus.byp_data_a = write_data_q;
  assign bus.byp_data_b = write_data_q;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: directed self-checking bench for writeback_arbiter.
// Inputs change 1 time unit after the rising edge; outputs are checked there.

module tb_writeback_arbiter;
  import wb_pkg::*;

  logic clock = 1'b0;
  logic ctrl_reset = 1'b0;

  always #5 clock = ~clock;

  writeback_arbiter_if #(.LQ_DEPTH(4)) bus ();

  writeback_arbiter #(
    .LQ_DEPTH     (4),
    .STARVE_LIMIT (3)
  ) dut (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .bus        (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    if (obs === want) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, want);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alu_valid = 1'b0;
    bus.alu_reg   = '0;
    bus.alu_data  = '0;
    bus.ld_valid  = 1'b0;
    bus.ld_reg    = '0;
    bus.ld_data   = '0;
  endtask

  // Hand-derived schedule for the fill/starvation run (STARVE_LIMIT=3, depth 4):
  // loads pushed in cycles 0..3, fifth offer refused at count 4; the FIFO is
  // forced to drain in cycles 4, 8, 12, 16.
  int exp_cnt [18] = '{1, 2, 3, 4, 3, 3, 3, 3, 2, 2, 2, 2, 1, 1, 1, 1, 0, 0};
  bit exp_ardy[18] = '{1, 1, 1, 1, 0, 1, 1, 1, 0, 1, 1, 1, 0, 1, 1, 1, 0, 1};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
`ifdef WB_BYPASS_EN
    bus.byp_reg_a = '0;
    bus.byp_reg_b = '0;
`endif

    // Reset state
    #2;
    check("rst_we",    32'(bus.ctrl_writeEnable), 32'd0);
    check("rst_reg",   32'(bus.ctrl_writeReg),    32'd0);
    check("rst_data",  bus.data_writeReg,         32'd0);
    check("rst_cnt",   32'(bus.lq_count),         32'd0);
    check("rst_ldrdy", 32'(bus.ld_ready),         32'd1);
    check("rst_alrdy", 32'(bus.alu_ready),        32'd1);
    tick();
    ctrl_reset = 1'b1;
    tick();

    // ALU only, latency 1
    bus.alu_valid = 1'b1; bus.alu_reg = 5'd5; bus.alu_data = 32'hDEADBEEF;
    tick();
    check("alu_we",   32'(bus.ctrl_writeEnable), 32'd1);
    check("alu_reg",  32'(bus.ctrl_writeReg),    32'd5);
    check("alu_data", bus.data_writeReg,         32'hDEADBEEF);
    idle_inputs();
    tick();
    check("idle_we",   32'(bus.ctrl_writeEnable), 32'd0);
    check("idle_reg",  32'(bus.ctrl_writeReg),    32'd5);
    check("idle_data", bus.data_writeReg,         32'hDEADBEEF);

    // Fill FIFO under continuous ALU traffic, forced drains
    for (int c = 0; c < 18; c++) begin
      bus.alu_valid = 1'b1;
      bus.alu_reg   = 5'd1;
      bus.alu_data  = 32'hA000 + 32'(c);
      bus.ld_valid  = (c < 5);
      bus.ld_reg    = 5'(20 + c);
      bus.ld_data   = 32'hB000 + 32'(c);
      check($sformatf("fill_ldrdy_%0d", c), 32'(bus.ld_ready),  (c == 4) ? 32'd0 : 32'd1);
      check($sformatf("fill_alrdy_%0d", c), 32'(bus.alu_ready), 32'(exp_ardy[c]));
      tick();
      check($sformatf("fill_we_%0d", c), 32'(bus.ctrl_writeEnable), 32'd1);
      if (exp_ardy[c]) begin
        check($sformatf("fill_reg_%0d", c),  32'(bus.ctrl_writeReg), 32'd1);
        check($sformatf("fill_data_%0d", c), bus.data_writeReg,      32'hA000 + 32'(c));
      end else begin
        check($sformatf("fill_reg_%0d", c),  32'(bus.ctrl_writeReg), 32'd20 + 32'((c - 4) / 4));
        check($sformatf("fill_data_%0d", c), bus.data_writeReg,      32'hB000 + 32'((c - 4) / 4));
      end
      check($sformatf("fill_cnt_%0d", c), 32'(bus.lq_count), 32'(exp_cnt[c]));
    end
    idle_inputs();
    tick();

    // Hazard: queued load to r7 killed by younger ALU write to r7
    bus.ld_valid = 1'b1; bus.ld_reg = 5'd7; bus.ld_data = 32'h77;
    tick();
    check("haz_push_we",  32'(bus.ctrl_writeEnable), 32'd0);
    check("haz_push_cnt", 32'(bus.lq_count),         32'd1);
    idle_inputs();
    bus.alu_valid = 1'b1; bus.alu_reg = 5'd7; bus.alu_data = 32'h1;
    tick();
    check("haz_alu_we",   32'(bus.ctrl_writeEnable), 32'd1);
    check("haz_alu_reg",  32'(bus.ctrl_writeReg),    32'd7);
    check("haz_alu_data", bus.data_writeReg,         32'h1);
    idle_inputs();
    tick();
    check("haz_pop_we",  32'(bus.ctrl_writeEnable), 32'd0);
    check("haz_pop_cnt", 32'(bus.lq_count),         32'd0);

    // Same-cycle ALU and load to r8: load is younger, stays valid
    bus.alu_valid = 1'b1; bus.alu_reg = 5'd8; bus.alu_data = 32'h2;
    bus.ld_valid  = 1'b1; bus.ld_reg  = 5'd8; bus.ld_data  = 32'h88;
    tick();
    check("same_alu_we",   32'(bus.ctrl_writeEnable), 32'd1);
    check("same_alu_data", bus.data_writeReg,         32'h2);
    idle_inputs();
    tick();
    check("same_ld_we",   32'(bus.ctrl_writeEnable), 32'd1);
    check("same_ld_reg",  32'(bus.ctrl_writeReg),    32'd8);
    check("same_ld_data", bus.data_writeReg,         32'h88);
    check("same_ld_cnt",  32'(bus.lq_count),         32'd0);

    // Register 0 from both sources
    bus.alu_valid = 1'b1; bus.alu_reg = 5'd0; bus.alu_data = 32'h1234;
    bus.ld_valid  = 1'b1; bus.ld_reg  = 5'd0; bus.ld_data  = 32'h5678;
    tick();
    check("r0_alu_we",  32'(bus.ctrl_writeEnable), 32'd0);
    check("r0_alu_cnt", 32'(bus.lq_count),         32'd1);
    idle_inputs();
    tick();
    check("r0_ld_we",  32'(bus.ctrl_writeEnable), 32'd0);
    check("r0_ld_cnt", 32'(bus.lq_count),         32'd0);

`ifdef WB_BYPASS_EN
    // Decode bypass
    bus.alu_valid = 1'b1; bus.alu_reg = 5'd9; bus.alu_data = 32'h55;
    tick();
    idle_inputs();
    bus.byp_reg_a = 5'd9; bus.byp_reg_b = 5'd0;
    #1;
    check("byp_hit_a",  32'(bus.byp_hit_a), 32'd1);
    check("byp_data_a", bus.byp_data_a,     32'h55);
    check("byp_hit_b",  32'(bus.byp_hit_b), 32'd0);
    bus.byp_reg_a = 5'd10;
    #1;
    check("byp_miss_a", 32'(bus.byp_hit_a), 32'd0);
    tick();
    bus.byp_reg_a = 5'd9;
    #1;
    check("byp_idle_a", 32'(bus.byp_hit_a), 32'd0);
    bus.byp_reg_a = '0;
`endif

    // Reset mid-traffic: two loads queued, an ALU write registered
    bus.ld_valid = 1'b1; bus.ld_reg = 5'd3; bus.ld_data = 32'h33;
    tick();
    bus.ld_reg = 5'd4; bus.ld_data = 32'h44;
    bus.alu_valid = 1'b1; bus.alu_reg = 5'd6; bus.alu_data = 32'h66;
    tick();
    check("pre_rst_we",  32'(bus.ctrl_writeEnable), 32'd1);
    check("pre_rst_cnt", 32'(bus.lq_count),         32'd2);
    ctrl_reset = 1'b0;
    #1;
    check("mid_rst_we",    32'(bus.ctrl_writeEnable), 32'd0);
    check("mid_rst_reg",   32'(bus.ctrl_writeReg),    32'd0);
    check("mid_rst_data",  bus.data_writeReg,         32'd0);
    check("mid_rst_cnt",   32'(bus.lq_count),         32'd0);
    check("mid_rst_ldrdy", 32'(bus.ld_ready),         32'd1);
    check("mid_rst_alrdy", 32'(bus.alu_ready),        32'd1);
    tick();
    check("hold_rst_we", 32'(bus.ctrl_writeEnable), 32'd0);
    idle_inputs();
    ctrl_reset = 1'b1;
    tick();
    check("post_rst_we",  32'(bus.ctrl_writeEnable), 32'd0);
    check("post_rst_cnt", 32'(bus.lq_count),         32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
